lcd_stream_ctrl: RTL and testbench

- Parametrised raster timing generator and pixel serialiser for parallel-RGB LCD panels; generalises the fixed 320x240, 3-channel LCD controller.
- Timing, channel count, bus width, sync polarities and pixel-fetch lookahead are all parameters.
- Adds a frame-aligned run/stop state machine, frame/line strobes and wrap-correct lookahead coordinates.
- Sits between the sprite compositor, which consumes req_x/req_y and returns rgb_data, and the panel pins.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_raster_counter.sv | 55 +++++
 rtl/lcd_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lcd_stream_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD stream controller.
//   - state_t      : run/stop state of the frame-aligned controller
//   - calc_total   : total period (visible + porches + sync) of one raster axis
//   - LCD_*        : default 320x240 panel timing
package lcd_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int LCD_H_VISIBLE = 320;
  localparam int LCD_H_FRONT   = 20;
  localparam int LCD_H_SYNC    = 30;
  localparam int LCD_H_BACK    = 38;
  localparam int LCD_V_VISIBLE = 240;
  localparam int LCD_V_FRONT   = 4;
  localparam int LCD_V_SYNC    = 3;
  localparam int LCD_V_BACK    = 15;

  function automatic int calc_total(input int visible, input int front,
                                    input int sync_w, input int back);
    return visible + front + sync_w + back;
  endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Beat / pixel / line counters for the raster scan.
//   clk, resetn : pixel-beat clock, async active-low reset
//   run         : advance when 1, hold at 0 when 0
//   beat        : beat within pixel (0..CHANNELS-1)
//   h_pos       : pixel within line (0..H_TOTAL-1)
//   v_pos       : line within frame (0..V_TOTAL-1)
//   frame_end   : current beat is the last beat of the frame
module lcd_raster_counter
  import lcd_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int H_TOTAL  = 408,
  parameter int V_TOTAL  = 262,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  output logic [1:0]    beat,
  output logic [CW-1:0] h_pos,
  output logic [CW-1:0] v_pos,
  output logic          frame_end
);

  localparam logic [1:0]    BEAT_LAST = 2'(CHANNELS - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

  logic beat_wrap;
  logic h_wrap;

  // With CHANNELS=1 BEAT_LAST is 0, so beat never leaves 0.
  assign beat_wrap = (beat == BEAT_LAST);
  assign h_wrap    = beat_wrap && (h_pos == H_LAST);
  assign frame_end = h_wrap && (v_pos == V_LAST);

  // NOTE: state registers use non-blocking assignments so every counter
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat  <= '0;
      h_pos <= '0;
      v_pos <= '0;
    end else if (!run) begin
      beat  <= '0;
      h_pos <= '0;
      v_pos <= '0;
    end else begin
      beat <= beat_wrap ? 2'd0 : beat + 2'd1;
      if (beat_wrap) h_pos <= (h_pos == H_LAST) ? '0 : h_pos + CW'(1);
      if (h_wrap)    v_pos <= (v_pos == V_LAST) ? '0 : v_pos + CW'(1);
    end
  end

endmodule

// File: rtl/lcd_stream_ctrl.sv
// Parametrised raster timing generator and pixel serialiser for parallel-RGB
// LCD panels.
//   clk, resetn        : pixel-beat clock, async active-low reset
//   en                 : run request, acted on only at frame boundaries
//   req_x/req_y        : coordinate whose pixel data the compositor must supply
//   req_active         : requested coordinate is visible
//   rgb_data           : pixel data, beat 0 in the MSB slice
//   lcd_dat            : serialised beat to the panel
//   lcd_hsync/vsync/den: panel timing, polarities set by *_ACT
//   frame_start/line_start : one-cycle strobes aligned with the panel outputs
//   running            : controller is in the RUN state
module lcd_stream_ctrl
  import lcd_pkg::*;
#(
  parameter int H_VISIBLE = LCD_H_VISIBLE,
  parameter int H_FRONT   = LCD_H_FRONT,
  parameter int H_SYNC    = LCD_H_SYNC,
  parameter int H_BACK    = LCD_H_BACK,
  parameter int V_VISIBLE = LCD_V_VISIBLE,
  parameter int V_FRONT   = LCD_V_FRONT,
  parameter int V_SYNC    = LCD_V_SYNC,
  parameter int V_BACK    = LCD_V_BACK,
  parameter int CHANNELS  = 3,
  parameter int DAT_W     = 8,
  parameter int LOOKAHEAD = 3,
  parameter bit HS_ACT    = 1'b0,
  parameter bit VS_ACT    = 1'b0,
  parameter bit DEN_ACT   = 1'b0,
  parameter int CW        = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  output logic [CW-1:0]             req_x,
  output logic [CW-1:0]             req_y,
  output logic                      req_active,
  input  logic [CHANNELS*DAT_W-1:0] rgb_data,
  output logic [DAT_W-1:0]          lcd_dat,
  output logic                      lcd_hsync,
  output logic                      lcd_vsync,
  output logic                      lcd_den,
  output logic                      frame_start,
  output logic                      line_start,
  output logic                      running
);

  localparam int H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int SW      = CW + 1;

  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      beat;
  logic [CW-1:0]   h_pos;
  logic [CW-1:0]   v_pos;
  logic            frame_end;
  logic [SW-1:0]   look_sum;
  logic [DAT_W-1:0] beat_data;
  logic            den_on;
  logic            hs_on;
  logic            vs_on;

  lcd_raster_counter #(
    .CHANNELS (CHANNELS),
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .CW       (CW)
  ) u_counter (
    .clk       (clk),
    .resetn    (resetn),
    .run       (running),
    .beat      (beat),
    .h_pos     (h_pos),
    .v_pos     (v_pos),
    .frame_end (frame_end)
  );

  // ---------------- run/stop FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_STOP;
    else         state <= state_nxt;
  end

  // NOTE: every signal written in a combinational block gets a default at the
  // top so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (en) state_nxt = ST_RUN;
      // Stopping only at the last beat keeps every frame complete.
      ST_RUN:  if (frame_end && !en) state_nxt = ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
  end

  // ---------------- lookahead request ----------------
  // In STOP the counters sit at 0, so this naturally prefetches the first
  // pixels of the next frame.
  always_comb begin
    look_sum = {1'b0, h_pos} + SW'(LOOKAHEAD);
    req_x    = look_sum[CW-1:0];
    req_y    = v_pos;
    if (look_sum >= SW'(H_TOTAL)) begin
      req_x = CW'(look_sum - SW'(H_TOTAL));
      req_y = (v_pos == V_LAST) ? '0 : v_pos + CW'(1);
    end
  end

  assign req_active = (req_x < H_VIS) && (req_y < V_VIS);

  // ---------------- serialiser and timing decode ----------------
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (beat == 2'(i)) beat_data = rgb_data[(CHANNELS-i)*DAT_W-1 -: DAT_W];
    end
  end

  assign den_on = (h_pos < H_VIS) && (v_pos < V_VIS);
  assign hs_on  = (h_pos >= HS_START) && (h_pos < HS_END);
  assign vs_on  = (v_pos >= VS_START) && (v_pos < VS_END);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lcd_dat     <= '0;
      lcd_hsync   <= ~HS_ACT;
      lcd_vsync   <= ~VS_ACT;
      lcd_den     <= ~DEN_ACT;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (state == ST_RUN) begin
      lcd_dat     <= beat_data;
      lcd_hsync   <= hs_on  ? HS_ACT  : ~HS_ACT;
      lcd_vsync   <= vs_on  ? VS_ACT  : ~VS_ACT;
      lcd_den     <= den_on ? DEN_ACT : ~DEN_ACT;
      frame_start <= (beat == 2'd0) && (h_pos == '0) && (v_pos == '0);
      line_start  <= (beat == 2'd0) && (h_pos == '0);
    end else begin
      lcd_dat     <= '0;
      lcd_hsync   <= ~HS_ACT;
      lcd_vsync   <= ~VS_ACT;
      lcd_den     <= ~DEN_ACT;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Directed bench for lcd_stream_ctrl on a 14x7 raster (H 8/2/2/2, V 4/1/1/1).
// dut  : CHANNELS=3, DAT_W=8, active-low syncs, LOOKAHEAD=3 (294 clk/frame)
// dut1 : CHANNELS=1, DAT_W=24, active-high hsync     (98 clk/frame)
module tb_lcd_stream_ctrl;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic resetn;
  logic en;
  logic en1;
  logic [23:0] rgb;
  logic [23:0] rgb1;

  logic [CW-1:0] req_x, req_y;
  logic          req_active;
  logic [7:0]    lcd_dat;
  logic          hs, vs, den, fs, ls, running;

  logic [CW-1:0] req_x1, req_y1;
  logic          req_active1;
  logic [23:0]   lcd_dat1;
  logic          hs1, vs1, den1, fs1, ls1, running1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_stream_ctrl #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CHANNELS(3), .DAT_W(8), .LOOKAHEAD(3),
    .HS_ACT(1'b0), .VS_ACT(1'b0), .DEN_ACT(1'b0), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en),
    .req_x(req_x), .req_y(req_y), .req_active(req_active),
    .rgb_data(rgb), .lcd_dat(lcd_dat),
    .lcd_hsync(hs), .lcd_vsync(vs), .lcd_den(den),
    .frame_start(fs), .line_start(ls), .running(running)
  );

  lcd_stream_ctrl #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CHANNELS(1), .DAT_W(24), .LOOKAHEAD(3),
    .HS_ACT(1'b1), .VS_ACT(1'b0), .DEN_ACT(1'b0), .CW(CW)
  ) dut1 (
    .clk(clk), .resetn(resetn), .en(en1),
    .req_x(req_x1), .req_y(req_y1), .req_active(req_active1),
    .rgb_data(rgb1), .lcd_dat(lcd_dat1),
    .lcd_hsync(hs1), .lcd_vsync(vs1), .lcd_den(den1),
    .frame_start(fs1), .line_start(ls1), .running(running1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 1'b0; en1 = 1'b0;
    rgb = 24'hA1B2C3; rgb1 = 24'h123456;
    step(); step();
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_running: got %b expected 0", running); end
    n_cmp++; if (den !== 1'b1) begin n_err++; $display("FAIL rst_den: got %b expected 1", den); end
    n_cmp++; if (hs !== 1'b1) begin n_err++; $display("FAIL rst_hsync: got %b expected 1", hs); end
    n_cmp++; if (vs !== 1'b1) begin n_err++; $display("FAIL rst_vsync: got %b expected 1", vs); end
    n_cmp++; if (lcd_dat !== 8'h00) begin n_err++; $display("FAIL rst_dat: got %h expected 00", lcd_dat); end
    n_cmp++; if ({fs, ls} !== 2'b00) begin n_err++; $display("FAIL rst_pulses: got %b expected 00", {fs, ls}); end
    n_cmp++; if ({req_x, req_y, req_active} !== {12'd3, 12'd0, 1'b1}) begin
      n_err++; $display("FAIL rst_req: got x=%0d y=%0d a=%b expected x=3 y=0 a=1", req_x, req_y, req_active);
    end
    n_cmp++; if (hs1 !== 1'b0) begin n_err++; $display("FAIL rst_hsync_act_high: got %b expected 0", hs1); end
    #2 resetn = 1'b1;
    step(); step();
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL idle_running: got %b expected 0", running); end
  endtask

  task automatic test_frame();
    int den_cnt = 0, hs_cnt = 0, vs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    logic [7:0] exp_dat;
    en = 1'b1;
    step();
    n_cmp++; if ({running, fs, den} !== 3'b101) begin
      n_err++; $display("FAIL start_first_clk: got run/fs/den=%b expected 101", {running, fs, den});
    end
    for (int i = 0; i < 294; i++) begin
      if (i == 12) begin
        n_cmp++; if ({req_x, req_y, req_active} !== {12'd7, 12'd0, 1'b1}) begin
          n_err++; $display("FAIL req_h4v0: got x=%0d y=%0d a=%b expected x=7 y=0 a=1", req_x, req_y, req_active);
        end
      end
      if (i == 120) begin
        n_cmp++; if ({req_x, req_y, req_active} !== {12'd1, 12'd3, 1'b1}) begin
          n_err++; $display("FAIL req_h12v2: got x=%0d y=%0d a=%b expected x=1 y=3 a=1", req_x, req_y, req_active);
        end
      end
      if (i == 183) begin
        n_cmp++; if ({req_x, req_y, req_active} !== {12'd8, 12'd4, 1'b0}) begin
          n_err++; $display("FAIL req_h5v4: got x=%0d y=%0d a=%b expected x=8 y=4 a=0", req_x, req_y, req_active);
        end
      end
      if (i == 288) begin
        n_cmp++; if ({req_x, req_y, req_active} !== {12'd1, 12'd0, 1'b1}) begin
          n_err++; $display("FAIL req_h12v6: got x=%0d y=%0d a=%b expected x=1 y=0 a=1", req_x, req_y, req_active);
        end
      end
      step();
      case (i % 3)
        0:       exp_dat = 8'hA1;
        1:       exp_dat = 8'hB2;
        default: exp_dat = 8'hC3;
      endcase
      n_cmp++; if (lcd_dat !== exp_dat) begin
        n_err++; $display("FAIL dat_seq[%0d]: got %h expected %h", i, lcd_dat, exp_dat);
      end
      if (i == 0) begin
        n_cmp++; if ({fs, ls} !== 2'b11) begin
          n_err++; $display("FAIL first_pulses: got fs/ls=%b expected 11", {fs, ls});
        end
      end
      if (den == 1'b0) den_cnt++;
      if (hs == 1'b0)  hs_cnt++;
      if (vs == 1'b0)  vs_cnt++;
      if (ls) ls_cnt++;
      if (fs) fs_cnt++;
    end
    n_cmp++; if (den_cnt !== 96) begin n_err++; $display("FAIL den_beats: got %0d expected 96", den_cnt); end
    n_cmp++; if (hs_cnt !== 42) begin n_err++; $display("FAIL hsync_beats: got %0d expected 42", hs_cnt); end
    n_cmp++; if (vs_cnt !== 42) begin n_err++; $display("FAIL vsync_beats: got %0d expected 42", vs_cnt); end
    n_cmp++; if (ls_cnt !== 7) begin n_err++; $display("FAIL line_starts: got %0d expected 7", ls_cnt); end
    n_cmp++; if (fs_cnt !== 1) begin n_err++; $display("FAIL frame_starts: got %0d expected 1", fs_cnt); end
    step();
    n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL frame_period: got fs=%b expected 1", fs); end
  endtask

  task automatic test_stop_midframe();
    int cnt = 0;
    int fs_seen = 0;
    int bad = 0;
    // Counters are at frame index 1 here; move to index 84 (v_pos 2).
    repeat (83) step();
    en = 1'b0;
    while (running === 1'b1 && cnt < 400) begin
      step();
      cnt++;
      if (fs) fs_seen++;
    end
    n_cmp++; if (cnt !== 210) begin n_err++; $display("FAIL stop_latency: got %0d clk expected 210", cnt); end
    n_cmp++; if (fs_seen !== 0) begin n_err++; $display("FAIL stop_no_fs: got %0d expected 0", fs_seen); end
    step();
    n_cmp++; if ({den, hs, vs, running, lcd_dat} !== {4'b1110, 8'h00}) begin
      n_err++; $display("FAIL stop_outputs: got den/hs/vs/run=%b dat=%h expected 1110 00", {den, hs, vs, running}, lcd_dat);
    end
    repeat (300) begin
      step();
      if (fs || running) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stop_idle: got %0d active clk expected 0", bad); end
    en = 1'b1;
    step();
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL restart_running: got %b expected 1", running); end
    step();
    n_cmp++; if ({fs, ls, lcd_dat} !== {2'b11, 8'hA1}) begin
      n_err++; $display("FAIL restart_origin: got fs/ls=%b dat=%h expected 11 a1", {fs, ls}, lcd_dat);
    end
  endtask

  task automatic test_async_reset();
    repeat (50) step();
    n_cmp++; if ({den, lcd_dat} !== {1'b0, 8'hC3}) begin
      n_err++; $display("FAIL pre_reset: got den=%b dat=%h expected 0 c3", den, lcd_dat);
    end
    #3 resetn = 1'b0;
    #1;
    n_cmp++; if ({running, den, hs, vs, fs, ls} !== 6'b011100) begin
      n_err++; $display("FAIL async_rst_ctrl: got run/den/hs/vs/fs/ls=%b expected 011100", {running, den, hs, vs, fs, ls});
    end
    n_cmp++; if (lcd_dat !== 8'h00) begin n_err++; $display("FAIL async_rst_dat: got %h expected 00", lcd_dat); end
    n_cmp++; if (req_x !== 12'd3) begin n_err++; $display("FAIL async_rst_req: got %0d expected 3", req_x); end
    #2 resetn = 1'b1;
    step();
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL post_rst_running: got %b expected 1", running); end
    step();
    n_cmp++; if ({fs, lcd_dat} !== {1'b1, 8'hA1}) begin
      n_err++; $display("FAIL post_rst_origin: got fs=%b dat=%h expected 1 a1", fs, lcd_dat);
    end
    en = 1'b0;
  endtask

  task automatic test_channels1();
    int hs_cnt = 0, den_cnt = 0, ls_cnt = 0;
    en1 = 1'b1;
    step();
    for (int i = 0; i < 98; i++) begin
      if (i == 5) begin
        n_cmp++; if ({req_x1, req_active1} !== {12'd8, 1'b0}) begin
          n_err++; $display("FAIL c1_req_h5: got x=%0d a=%b expected x=8 a=0", req_x1, req_active1);
        end
      end
      if (i == 96) begin
        n_cmp++; if ({req_x1, req_y1, req_active1} !== {12'd1, 12'd0, 1'b1}) begin
          n_err++; $display("FAIL c1_req_wrap: got x=%0d y=%0d a=%b expected x=1 y=0 a=1", req_x1, req_y1, req_active1);
        end
      end
      step();
      n_cmp++; if (lcd_dat1 !== 24'h123456) begin
        n_err++; $display("FAIL c1_dat[%0d]: got %h expected 123456", i, lcd_dat1);
      end
      if (i == 0) begin
        n_cmp++; if ({fs1, ls1} !== 2'b11) begin n_err++; $display("FAIL c1_first_pulses: got %b expected 11", {fs1, ls1}); end
      end
      if (i == 10) begin
        n_cmp++; if (hs1 !== 1'b1) begin n_err++; $display("FAIL c1_hs_h10: got %b expected 1", hs1); end
      end
      if (i == 12) begin
        n_cmp++; if (hs1 !== 1'b0) begin n_err++; $display("FAIL c1_hs_h12: got %b expected 0", hs1); end
      end
      if (hs1) hs_cnt++;
      if (den1 == 1'b0) den_cnt++;
      if (ls1) ls_cnt++;
    end
    n_cmp++; if (hs_cnt !== 14) begin n_err++; $display("FAIL c1_hsync_clk: got %0d expected 14", hs_cnt); end
    n_cmp++; if (den_cnt !== 32) begin n_err++; $display("FAIL c1_den_clk: got %0d expected 32", den_cnt); end
    n_cmp++; if (ls_cnt !== 7) begin n_err++; $display("FAIL c1_line_starts: got %0d expected 7", ls_cnt); end
    step();
    n_cmp++; if (fs1 !== 1'b1) begin n_err++; $display("FAIL c1_frame_period: got %b expected 1", fs1); end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stop_midframe();
    test_async_reset();
    test_channels1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
